// File: rtl/write_pointer_ctrl.sv
// Base write/read pointer controller for a multi-lane circular buffer.
// Pointers carry a wrap bit in the MSB so full and empty can be told apart.
module write_pointer_ctrl #(
  parameter int PTR_WIDTH = 8,
  parameter int LANES     = 4
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 push_valid,
  input  logic [2:0]           push_count,
  output logic                 push_ready,
  input  logic                 pop_valid,
  input  logic [2:0]           pop_count,
  output logic                 pop_ready,
  input  logic                 flush,
  output logic [PTR_WIDTH-1:0] write_pointer,
  output logic [PTR_WIDTH-1:0] read_pointer,
  output logic [PTR_WIDTH-1:0] occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam logic [PTR_WIDTH-1:0] DEPTH    = {1'b1, {(PTR_WIDTH-1){1'b0}}};
  localparam logic [2:0]           LANES_C  = 3'(LANES);

  logic [PTR_WIDTH-1:0] wp_q, wp_d;
  logic [PTR_WIDTH-1:0] rp_q, rp_d;
  logic [PTR_WIDTH-1:0] occ_q, occ_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 err_q, err_d;

  logic [PTR_WIDTH-1:0] free;
  logic [PTR_WIDTH-1:0] push_amt;
  logic [PTR_WIDTH-1:0] pop_amt;
  logic                 push_acc;
  logic                 pop_acc;

  // Handshake: a transfer of N entries happens on a rising edge where valid
  // and ready are both high (and flush is low). ready depends only on the
  // requested count and registered state, never on valid. A request that is
  // not ready moves nothing; the requester holds it and retries.
  assign free     = DEPTH - occ_q;
  assign push_amt = {{(PTR_WIDTH-3){1'b0}}, push_count};
  assign pop_amt  = {{(PTR_WIDTH-3){1'b0}}, pop_count};

  assign push_ready = (push_amt <= free) && (push_count <= LANES_C);
  assign pop_ready  = (pop_amt <= occ_q) && (pop_count <= LANES_C);

  assign push_acc = push_valid && push_ready && !flush;
  assign pop_acc  = pop_valid && pop_ready && !flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    occ_d   = occ_q;
    err_d   = err_q;

    if ((push_valid && (push_count > LANES_C)) ||
        (pop_valid && (pop_count > LANES_C))) begin
      err_d = 1'b1;
    end

    if (flush) begin
      rp_d  = wp_q;
      occ_d = '0;
    end else begin
      if (push_acc) wp_d = wp_q + push_amt;
      if (pop_acc)  rp_d = rp_q + pop_amt;
      occ_d = occ_q + (push_acc ? push_amt : '0) - (pop_acc ? pop_amt : '0);
    end

    // Flags come from the next pointers so they register alongside them.
    full_d  = (wp_d ^ rp_d) == DEPTH;
    empty_d = (wp_d == rp_d);
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign write_pointer = wp_q;
  assign read_pointer  = rp_q;
  assign occupancy     = occ_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign err           = err_q;

endmodule

// File: tb/tb_write_pointer_ctrl.sv
// Directed bench for write_pointer_ctrl: fill/drain, wrap, flush, illegal
// counts and asynchronous reset, against hand-computed expected values.
module tb_write_pointer_ctrl;

  logic       CLK;
  logic       ASYNCRESETN;
  logic       push_valid;
  logic [2:0] push_count;
  logic       push_ready;
  logic       pop_valid;
  logic [2:0] pop_count;
  logic       pop_ready;
  logic       flush;
  logic [7:0] write_pointer;
  logic [7:0] read_pointer;
  logic [7:0] occupancy;
  logic       full;
  logic       empty;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  write_pointer_ctrl #(.PTR_WIDTH(8), .LANES(4)) dut (
    .CLK           (CLK),
    .ASYNCRESETN   (ASYNCRESETN),
    .push_valid    (push_valid),
    .push_count    (push_count),
    .push_ready    (push_ready),
    .pop_valid     (pop_valid),
    .pop_count     (pop_count),
    .pop_ready     (pop_ready),
    .flush         (flush),
    .write_pointer (write_pointer),
    .read_pointer  (read_pointer),
    .occupancy     (occupancy),
    .full          (full),
    .empty         (empty),
    .err           (err)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [2:0] pc,
                       input logic ov, input logic [2:0] oc, input logic fl);
    push_valid = pv;
    push_count = pc;
    pop_valid  = ov;
    pop_count  = oc;
    flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    push_valid = 1'b0;
    push_count = 3'd0;
    pop_valid  = 1'b0;
    pop_count  = 3'd0;
    flush      = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] wp, input logic [7:0] rp,
                             input logic [7:0] occ, input logic f, input logic e);
    check({tag, ".wp"}, 32'(write_pointer), 32'(wp));
    check({tag, ".rp"}, 32'(read_pointer), 32'(rp));
    check({tag, ".occ"}, 32'(occupancy), 32'(occ));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".empty"}, 32'(empty), 32'(e));
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    push_valid  = 1'b0;
    push_count  = 3'd0;
    pop_valid   = 1'b0;
    pop_count   = 3'd0;
    flush       = 1'b0;
    #12;
    check_state("reset", 8'h00, 8'h00, 8'd0, 1'b0, 1'b1);
    check("reset.err", 32'(err), 32'd0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    // first push right after reset release
    drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
    check("push4.ready", 32'(push_ready), 32'd1);
    tick();
    check_state("push4", 8'h04, 8'h00, 8'd4, 1'b0, 1'b0);

    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
      tick();
    end
    check_state("fill", 8'h80, 8'h00, 8'd128, 1'b1, 1'b0);

    drive(1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
    check("full.push_ready", 32'(push_ready), 32'd0);
    tick();
    check_state("full.push1", 8'h80, 8'h00, 8'd128, 1'b1, 1'b0);

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 3'd0, 1'b1, 3'd4, 1'b0);
      tick();
    end
    check_state("drain", 8'h80, 8'h80, 8'd0, 1'b0, 1'b1);

    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
    tick();
    check_state("occ126", 8'hFE, 8'h80, 8'd126, 1'b0, 1'b0);

    // push 3 does not fit into 2 free slots: nothing written
    drive(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
    check("push3.ready", 32'(push_ready), 32'd0);
    tick();
    check_state("push3.atomic", 8'hFE, 8'h80, 8'd126, 1'b0, 1'b0);

    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b0);
    tick();
    check_state("wrap.push2pop3", 8'h00, 8'h83, 8'd125, 1'b0, 1'b0);

    drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0);
    check("zero.push_ready", 32'(push_ready), 32'd1);
    tick();
    check_state("zero.noop", 8'h00, 8'h83, 8'd125, 1'b0, 1'b0);

    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    check_state("flush", 8'h00, 8'h00, 8'd0, 1'b0, 1'b1);

    drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b0); tick();
    drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b0); tick();
    drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b0); tick();
    check_state("occ10", 8'h0A, 8'h00, 8'd10, 1'b0, 1'b0);

    drive(1'b1, 3'd4, 1'b1, 3'd2, 1'b1);
    tick();
    check_state("flush.prio", 8'h0A, 8'h0A, 8'd0, 1'b0, 1'b1);

    drive(1'b0, 3'd0, 1'b1, 3'd1, 1'b0);
    check("empty.pop_ready", 32'(pop_ready), 32'd0);
    tick();
    check_state("empty.pop1", 8'h0A, 8'h0A, 8'd0, 1'b0, 1'b1);

    drive(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 1'b1, 3'd4, 1'b0);
    check("pop4.ready", 32'(pop_ready), 32'd0);
    tick();
    check_state("pop4.atomic", 8'h0D, 8'h0A, 8'd3, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
    check("pop3.ready", 32'(pop_ready), 32'd1);
    tick();
    check_state("pop3", 8'h0D, 8'h0D, 8'd0, 1'b0, 1'b1);

    check("err.before", 32'(err), 32'd0);
    drive(1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
    check("push5.ready", 32'(push_ready), 32'd0);
    tick();
    check_state("push5", 8'h0D, 8'h0D, 8'd0, 1'b0, 1'b1);
    check("push5.err", 32'(err), 32'd1);
    drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
    tick();
    check_state("after.err", 8'h11, 8'h0D, 8'd4, 1'b0, 1'b0);
    check("err.sticky", 32'(err), 32'd1);

    // asynchronous reset between edges with a push in flight
    drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
    @(posedge CLK);
    #2;
    check("mid.wp_pre", 32'(write_pointer), 32'h15);
    ASYNCRESETN = 1'b0;
    #1;
    check_state("async", 8'h00, 8'h00, 8'd0, 1'b0, 1'b1);
    check("async.err", 32'(err), 32'd0);
    @(posedge CLK);
    #1;
    check_state("held", 8'h00, 8'h00, 8'd0, 1'b0, 1'b1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    tick();
    check_state("first.accept", 8'h04, 8'h00, 8'd4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/write_pointer_ctrl.md
WRITE_POINTER_CTRL -- requirements
Module: write_pointer_ctrl

Interface
REQ-001 Parameter: PTR_WIDTH, default 8, pointer width; MSB is the wrap bit, so buffer depth = 2^(PTR_WIDTH-1) = 128.
REQ-002 Parameter: LANES, default 4, maximum entries pushed or popped per cycle.
REQ-003 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: ASYNCRESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: push_valid  input  1  producer requests a push.
REQ-006 Port: push_count  input  3  number of entries to push, 0..LANES.
REQ-007 Port: push_ready  output  1  the requested push_count fits now.
REQ-008 Port: pop_valid  input  1  consumer requests a pop.
REQ-009 Port: pop_count  input  3  number of entries to pop, 0..LANES.
REQ-010 Port: pop_ready  output  1  the requested pop_count is available now.
REQ-011 Port: flush  input  1  synchronous discard of all stored entries.
REQ-012 Port: write_pointer  output  PTR_WIDTH  registered base write pointer for the downstream lane-pointer stage.
REQ-013 Port: read_pointer  output  PTR_WIDTH  registered base read pointer.
REQ-014 Port: occupancy  output  PTR_WIDTH  stored entries, 0..128.
REQ-015 Port: full, empty  output  1 each  occupancy==128 / occupancy==0.
REQ-016 Port: err  output  1  sticky flag for an illegal count.

Function
REQ-017 free = 128 - occupancy, computed from registered state only; a same-cycle pop grants no push credit.
REQ-018 push_ready = (push_count <= free) && (push_count <= LANES), combinational.
REQ-019 pop_ready = (pop_count <= occupancy) && (pop_count <= LANES), combinational.
REQ-020 Push accepted = push_valid && push_ready && !flush; write_pointer += push_count mod 2^PTR_WIDTH, visible the next cycle.
REQ-021 Pop accepted = pop_valid && pop_ready && !flush; read_pointer += pop_count mod 2^PTR_WIDTH, visible the next cycle.
REQ-022 Simultaneous accepted push and pop: both applied in one cycle; occupancy_next = occupancy + push_count - pop_count.
REQ-023 Count of 0 with valid: accepted as a no-op; pointers and occupancy unchanged.
REQ-024 A push is atomic: if push_count > free, nothing is written (no partial push), and the producer holds its request.
REQ-025 A pop is atomic under the same rule as REQ-024.
REQ-026 push_count or pop_count > LANES with its valid high: that request is ignored and err is set to 1 until reset.
REQ-027 Wrap-around: pointers wrap modulo 256 (e.g. 0xFE + 3 = 0x01); the MSB toggles every 128 entries.
REQ-028 The invariant occupancy == (write_pointer - read_pointer) mod 256 SHALL hold on every cycle.
REQ-029 full is asserted iff the pointers differ only in the MSB; empty is asserted iff the pointers are equal; both are registered.
REQ-030 flush has priority over push and pop in the same cycle: read_pointer_next = write_pointer, occupancy_next = 0, write_pointer unchanged.
REQ-031 All outputs other than push_ready and pop_ready are driven directly from flops.

Reset
REQ-032 ASYNCRESETN low immediately clears write_pointer, read_pointer, occupancy and err to 0, sets empty=1 and full=0, independent of CLK.
REQ-033 Reset asserted mid-operation discards the in-flight push/pop; no state update occurs while ASYNCRESETN is low.
REQ-034 The first accept is possible on the first rising edge after ASYNCRESETN deasserts.

Verification
REQ-035 Reset, then push 4 -> next cycle write_pointer=0x04, occupancy=4, empty=0.
REQ-036 Fill with 32 pushes of 4 -> occupancy=128, full=1, write_pointer=0x80, read_pointer=0x00; push 1 -> push_ready=0, no change.
REQ-037 At occupancy=126, write_pointer=0xFE: push 2 with pop 3 the same cycle -> write_pointer=0x00, occupancy=125.
REQ-038 push_count=5 with push_valid -> pointers unchanged, err=1 and it persists across later legal traffic until reset.
REQ-039 flush with concurrent push 4 and pop 2 at occupancy=10 -> read_pointer=write_pointer (unchanged), occupancy=0, empty=1.
REQ-040 Assert ASYNCRESETN mid-stream between clock edges -> all state is 0 and empty=1 before the next CLK edge.
